// File: rtl/event_blinker_pkg.sv
// Shared definitions for the event blinker: state encoding and the
// elaboration-time helpers that size the prescaler and tick counter.
package event_blinker_pkg;

   // Blinker FSM states; o_out is high only in ST_ON.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_e;

   // Clock cycles per timing tick; never below 1 so the prescaler stays legal.
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned tick_hz);
      int unsigned div;
      div = (tick_hz == 0) ? 1 : clk_hz / tick_hz;
      if (div == 0) div = 1;
      return div;
   endfunction

   // Bits needed for a counter that must represent max_val (at least 1 bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max_u(input int unsigned a,
                                         input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/event_blinker_tick_gen.sv
// tick_gen: clearable prescaler producing a one-cycle tick every DIV cycles.
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   clear  - force the count to 0 on the next edge (priority over enable)
//   enable - advance the count on the next edge
//   tick   - registered, high during the cycle in which the count is DIV-1
// clear/enable qualify the count of the *next* cycle so the registered tick
// lines up exactly with count == DIV-1.
module tick_gen
   import event_blinker_pkg::*;
#(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CNT_W = cnt_width(DIV - 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Next count and the tick that coincides with it.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      tick_d = enable && (cnt_d == LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/event_blinker.sv
// event_blinker: stretches single-cycle events into human-visible pulses of
// ON_TICKS ticks separated by at least OFF_TICKS ticks, queuing events that
// arrive while a pulse or gap is in progress.
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset, clears the queue
//   i_pulse   - one event per high cycle
//   o_out     - stretched pulse (registered, high in ON)
//   o_busy    - registered, high whenever not IDLE
//   o_pending - queued events not yet started
//   o_drop    - one cycle per event lost to a full queue
module event_blinker
   import event_blinker_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned TICK_HZ   = 1_000,
   parameter int unsigned ON_TICKS  = 100,
   parameter int unsigned OFF_TICKS = 100,
   parameter int unsigned PEND_W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_pulse,
   output logic              o_out,
   output logic              o_busy,
   output logic [PEND_W-1:0] o_pending,
   output logic              o_drop
);

   localparam int unsigned DIV    = calc_div(CLK_HZ, TICK_HZ);
   localparam int unsigned TCNT_W = cnt_width(max_u(ON_TICKS, OFF_TICKS));
   localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
   localparam logic [TCNT_W-1:0] OFF_LAST = TCNT_W'(OFF_TICKS - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   state_e              state_q, state_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [PEND_W-1:0]   pend_q, pend_d;
   logic                out_q, out_d;
   logic                busy_q, busy_d;
   logic                drop_q, drop_d;
   logic                have_evt;
   logic                start;
   logic                tick;
   logic                tg_clear;
   logic                tg_enable;

   // Prescaler restarts on every state change and idles at 0.
   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .clear  (tg_clear),
      .enable (tg_enable),
      .tick   (tick)
   );

   // Next state, tick counter, event queue and registered output decode.
   always_comb begin
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      pend_d    = pend_q;
      drop_d    = 1'b0;
      out_d     = 1'b0;
      busy_d    = 1'b0;
      tg_clear  = 1'b0;
      tg_enable = 1'b0;
      start     = 1'b0;
      have_evt  = i_pulse || (pend_q != '0);

      case (state_q)
         ST_IDLE: begin
            if (have_evt) state_d = ST_ON;
         end
         ST_ON: begin
            if (tick && (tcnt_q == ON_LAST)) state_d = ST_OFF;
         end
         ST_OFF: begin
            if (tick && (tcnt_q == OFF_LAST)) state_d = have_evt ? ST_ON : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      start = (state_d == ST_ON) && (state_q != ST_ON);

      // Tick counter and prescaler both restart on entry and hold 0 in IDLE.
      tg_clear  = (state_d != state_q) || (state_d == ST_IDLE);
      tg_enable = (state_d != ST_IDLE);
      if (tg_clear) begin
         tcnt_d = '0;
      end else if (tick) begin
         tcnt_d = tcnt_q + TCNT_W'(1);
      end

      // A start consumes the live pulse first; only otherwise the queue.
      if (start && !i_pulse) begin
         pend_d = pend_q - PEND_W'(1);
      end else if (i_pulse && !start) begin
         if (pend_q == PEND_MAX) drop_d = 1'b1;
         else                    pend_d = pend_q + PEND_W'(1);
      end

      out_d  = (state_d == ST_ON);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         tcnt_q  <= '0;
         pend_q  <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         pend_q  <= pend_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   assign o_out     = out_q;
   assign o_busy    = busy_q;
   assign o_pending = pend_q;
   assign o_drop    = drop_q;

endmodule

// File: tb/tb_event_blinker.sv
// Directed bench for event_blinker with DIV=10, ON_TICKS=3, OFF_TICKS=2, PEND_W=2.
// Cycle c is the interval following the c-th rising edge after reset release.
module tb_event_blinker;

   localparam int unsigned PEND_W = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              i_pulse = 1'b0;
   logic              o_out;
   logic              o_busy;
   logic [PEND_W-1:0] o_pending;
   logic              o_drop;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   event_blinker #(
      .CLK_HZ    (10),
      .TICK_HZ   (1),
      .ON_TICKS  (3),
      .OFF_TICKS (2),
      .PEND_W    (PEND_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_pulse   (i_pulse),
      .o_out     (o_out),
      .o_busy    (o_busy),
      .o_pending (o_pending),
      .o_drop    (o_drop)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      i_pulse = 1'b0;
      repeat (3) step();
      reset = 1'b1;
   endtask

   function automatic logic in_win(input int c, input int s, input int len);
      return (c >= s) && (c < s + len);
   endfunction

   // Pulse-width / gap / drop properties, sampled on the falling edge.
   int   run_len = 0;
   int   gap_len = 0;
   logic prev_out = 1'b0;
   logic prev_drop = 1'b0;
   logic seen_run = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         run_len = 0; gap_len = 0; prev_out = 1'b0; prev_drop = 1'b0; seen_run = 1'b0;
      end else begin
         if (o_out) begin
            if (!prev_out && seen_run) begin
               n_checks++;
               if (gap_len < 20) $display("FAIL prop_gap: got %0d cycles want >= 20", gap_len);
               else n_pass++;
            end
            run_len = prev_out ? run_len + 1 : 1;
         end else begin
            if (prev_out) begin
               n_checks++;
               if (run_len != 30) $display("FAIL prop_run: got %0d cycles want 30", run_len);
               else n_pass++;
               seen_run = 1'b1;
            end
            gap_len = prev_out ? 1 : gap_len + 1;
         end
         if (o_drop) begin
            n_checks++;
            if (prev_drop) $display("FAIL prop_drop2: o_drop high two cycles at %0t", $time);
            else n_pass++;
         end
         prev_out  = o_out;
         prev_drop = o_drop;
      end
   end

   task automatic test_reset();
      reset   = 1'b0;
      i_pulse = 1'b1;
      step();
      n_checks++; if (o_out !== 1'b0)  $display("FAIL reset_out: got %b want 0", o_out);  else n_pass++;
      n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
      n_checks++; if (o_pending !== 2'd0) $display("FAIL reset_pend: got %0d want 0", o_pending); else n_pass++;
      n_checks++; if (o_drop !== 1'b0) $display("FAIL reset_drop: got %b want 0", o_drop); else n_pass++;
      i_pulse = 1'b0;
   endtask

   task automatic test_single();
      logic eo, eb;
      do_reset();
      for (int c = 0; c <= 60; c++) begin
         eo = in_win(c, 1, 30);
         eb = in_win(c, 1, 50);
         n_checks++; if (o_out !== eo)  $display("FAIL single_out c=%0d: got %b want %b", c, o_out, eo);  else n_pass++;
         n_checks++; if (o_busy !== eb) $display("FAIL single_busy c=%0d: got %b want %b", c, o_busy, eb); else n_pass++;
         n_checks++; if (o_pending !== 2'd0) $display("FAIL single_pend c=%0d: got %0d want 0", c, o_pending); else n_pass++;
         i_pulse = (c == 0);
         step();
      end
      i_pulse = 1'b0;
   endtask

   task automatic test_queue();
      logic       eo, eb;
      logic [1:0] ep;
      do_reset();
      for (int c = 0; c <= 160; c++) begin
         eo = in_win(c, 1, 30) || in_win(c, 51, 30) || in_win(c, 101, 30);
         eb = in_win(c, 1, 150);
         ep = (c < 6) ? 2'd0 : (c == 6) ? 2'd1 : (c <= 50) ? 2'd2 : (c <= 100) ? 2'd1 : 2'd0;
         n_checks++; if (o_out !== eo)  $display("FAIL queue_out c=%0d: got %b want %b", c, o_out, eo);  else n_pass++;
         n_checks++; if (o_busy !== eb) $display("FAIL queue_busy c=%0d: got %b want %b", c, o_busy, eb); else n_pass++;
         n_checks++; if (o_pending !== ep) $display("FAIL queue_pend c=%0d: got %0d want %0d", c, o_pending, ep); else n_pass++;
         i_pulse = (c == 0) || (c == 5) || (c == 6);
         step();
      end
      i_pulse = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic eo, eb;
      do_reset();
      for (int c = 0; c <= 110; c++) begin
         eo = in_win(c, 1, 30) || in_win(c, 51, 30);
         eb = in_win(c, 1, 100);
         n_checks++; if (o_out !== eo)  $display("FAIL b2b_out c=%0d: got %b want %b", c, o_out, eo);  else n_pass++;
         n_checks++; if (o_busy !== eb) $display("FAIL b2b_busy c=%0d: got %b want %b", c, o_busy, eb); else n_pass++;
         n_checks++; if (o_pending !== 2'd0) $display("FAIL b2b_pend c=%0d: got %0d want 0", c, o_pending); else n_pass++;
         i_pulse = (c == 0) || (c == 50);
         step();
      end
      i_pulse = 1'b0;
   endtask

   task automatic test_saturate();
      logic       eo, eb, ed;
      logic [1:0] ep;
      do_reset();
      for (int c = 0; c <= 210; c++) begin
         eo = in_win(c, 1, 30) || in_win(c, 51, 30) || in_win(c, 101, 30) || in_win(c, 151, 30);
         eb = in_win(c, 1, 200);
         ed = (c == 5);
         ep = (c < 2) ? 2'd0 : (c == 2) ? 2'd1 : (c == 3) ? 2'd2 : (c <= 50) ? 2'd3 :
              (c <= 100) ? 2'd2 : (c <= 150) ? 2'd1 : 2'd0;
         n_checks++; if (o_out !== eo)  $display("FAIL sat_out c=%0d: got %b want %b", c, o_out, eo);  else n_pass++;
         n_checks++; if (o_busy !== eb) $display("FAIL sat_busy c=%0d: got %b want %b", c, o_busy, eb); else n_pass++;
         n_checks++; if (o_drop !== ed) $display("FAIL sat_drop c=%0d: got %b want %b", c, o_drop, ed); else n_pass++;
         n_checks++; if (o_pending !== ep) $display("FAIL sat_pend c=%0d: got %0d want %0d", c, o_pending, ep); else n_pass++;
         i_pulse = (c <= 4);
         step();
      end
      i_pulse = 1'b0;
   endtask

   task automatic test_reset_mid_on();
      do_reset();
      for (int c = 0; c < 15; c++) begin
         i_pulse = (c <= 2);
         step();
      end
      i_pulse = 1'b0;
      n_checks++; if (o_out !== 1'b1) $display("FAIL midrst_pre_out: got %b want 1", o_out); else n_pass++;
      n_checks++; if (o_pending !== 2'd2) $display("FAIL midrst_pre_pend: got %0d want 2", o_pending); else n_pass++;
      reset = 1'b0;
      #2;
      n_checks++; if (o_out !== 1'b0)  $display("FAIL midrst_out: got %b want 0", o_out);  else n_pass++;
      n_checks++; if (o_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", o_busy); else n_pass++;
      n_checks++; if (o_pending !== 2'd0) $display("FAIL midrst_pend: got %0d want 0", o_pending); else n_pass++;
      step();
      step();
      reset = 1'b1;
      for (int c = 0; c < 100; c++) begin
         n_checks++; if (o_out !== 1'b0)  $display("FAIL postrst_out c=%0d: got %b want 0", c, o_out);  else n_pass++;
         n_checks++; if (o_busy !== 1'b0) $display("FAIL postrst_busy c=%0d: got %b want 0", c, o_busy); else n_pass++;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_queue();
      test_back_to_back();
      test_saturate();
      test_reset_mid_on();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
